// File: rtl/tio_sync_gen.sv
// tio_sync_gen: delayed sync pulse generator with sysclk counter and sync-sequence phase reload
module tio_sync_gen #(
  parameter int SEQ_LEN      = 8,
  parameter int EXT_SYNC_LEN = 4,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sync_req_i,
  input  logic [7:0]                   sync_offset_i,
  input  logic                         en_ext_sync_i,
  input  logic [7:0]                   clk_offset_i,
  output logic                         sync_o,
  output logic                         ext_sync_o,
  output logic [$clog2(SEQ_LEN)-1:0]   seq_phase_o,
  output logic [COUNT_WIDTH-1:0]       sysclk_count_o,
  output logic                         busy_o,
  output logic                         req_drop_o
);
  localparam int PW = $clog2(SEQ_LEN);
  localparam int CW = (EXT_SYNC_LEN > 257) ? $clog2(EXT_SYNC_LEN) : 8;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic en_q, en_d;
  logic [7:0] off_q, off_d;
  logic sync_q, sync_d, ext_q, ext_d, busy_q, busy_d, drop_q, drop_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      off_q   <= '0;
      sync_q  <= 1'b0;
      ext_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      phase_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      off_q   <= off_d;
      sync_q  <= sync_d;
      ext_q   <= ext_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end
  // cnt_q counts the remaining WAIT cycles, then the remaining HOLD cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    off_d   = off_q;
    if (state_q == IDLE && sync_req_i) begin
      state_d = WAIT;
      cnt_d   = CW'(sync_offset_i);
      en_d    = en_ext_sync_i;
      off_d   = clk_offset_i;
    end else if (state_q == WAIT) begin
      state_d = (cnt_q != '0) ? WAIT : ((en_q && EXT_SYNC_LEN > 1) ? HOLD : IDLE);
      cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : CW'(EXT_SYNC_LEN - 2);
    end else if (state_q == HOLD) begin
      state_d = (cnt_q == '0) ? IDLE : HOLD;
      cnt_d   = cnt_q - CW'(1);
    end
  end
  always_comb begin
    sync_d  = state_d == WAIT && cnt_d == '0;
    ext_d   = (sync_d && en_d) || state_d == HOLD;
    busy_d  = state_d != IDLE;
    drop_d  = sync_req_i && busy_q;
    phase_d = (sync_q || phase_q == PW'(SEQ_LEN - 1)) ? '0 : phase_q + PW'(1);
    count_d = sync_q ? COUNT_WIDTH'(off_q) : count_q + COUNT_WIDTH'(1);
  end
  assign sync_o         = sync_q;
  assign ext_sync_o     = ext_q;
  assign busy_o         = busy_q;
  assign req_drop_o     = drop_q;
  assign seq_phase_o    = phase_q;
  assign sysclk_count_o = count_q;
endmodule

// File: tb/tb_tio_sync_gen.sv
// tb_tio_sync_gen: directed checks of tio_sync_gen timing, drops, reset and wraps
module tb_tio_sync_gen;
  logic clk = 1'b0;
  logic rst, sync_req, en_ext, sync, ext, busy, drop;
  logic [7:0] sync_offset, clk_offset, count;
  logic [2:0] phase;
  int errors = 0;
  int checks = 0;
  tio_sync_gen #(.SEQ_LEN(8), .EXT_SYNC_LEN(4), .COUNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .sync_req_i(sync_req), .sync_offset_i(sync_offset),
    .en_ext_sync_i(en_ext), .clk_offset_i(clk_offset), .sync_o(sync), .ext_sync_o(ext),
    .seq_phase_o(phase), .sysclk_count_o(count), .busy_o(busy), .req_drop_o(drop)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, ".sync"}, sync, 0);
    chk({tag, ".ext"}, ext, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".drop"}, drop, 0);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".phase"}, phase, 0);
  endtask
  // one request of offset n; perturb changes the inputs right after acceptance
  task automatic req_seq(input int n, input bit en, input logic [7:0] off, input bit perturb);
    int last;
    tick();
    sync_offset = 8'(n);
    en_ext = en;
    clk_offset = off;
    sync_req = 1'b1;
    last = en ? n + 4 : n + 1;
    for (int k = 1; k <= n + 6; k++) begin
      tick();
      sync_req = 1'b0;
      if (perturb) begin
        sync_offset = 8'd20;
        en_ext = ~en;
        clk_offset = 8'hEE;
      end
      chk($sformatf("seq%0d.sync@%0d", n, k), sync, k == n + 1);
      chk($sformatf("seq%0d.ext@%0d", n, k), ext, en && k >= n + 1 && k <= n + 4);
      chk($sformatf("seq%0d.busy@%0d", n, k), busy, k <= last);
      if (k == n + 2) begin
        chk($sformatf("seq%0d.count", n), count, off);
        chk($sformatf("seq%0d.phase", n), phase, 0);
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    sync_req = 1'b0;
    en_ext = 1'b0;
    sync_offset = 8'd0;
    clk_offset = 8'd0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    req_seq(0, 1'b0, 8'h10, 1'b0);
    req_seq(5, 1'b1, 8'h20, 1'b0);
    req_seq(3, 1'b0, 8'h30, 1'b1);
    // drop during wait, drop in the final WAIT cycle, accept right after busy falls
    tick();
    sync_offset = 8'd5;
    en_ext = 1'b0;
    clk_offset = 8'h40;
    sync_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      sync_req = 1'b0;
      chk($sformatf("drop.sync@%0d", k), sync, k == 6 || k == 8);
      if (k == 2) sync_req = 1'b1;
      if (k == 3) chk("drop.pulse", drop, 1);
      if (k == 4) chk("drop.clear", drop, 0);
      if (k == 6) begin
        sync_req = 1'b1;
        sync_offset = 8'd0;
      end
      if (k == 7) begin
        chk("drop.final_wait", drop, 1);
        chk("drop.busy_fell", busy, 0);
        sync_req = 1'b1;
      end
      if (k == 8) begin
        chk("drop.accept_busy", busy, 1);
        chk("drop.accept_nodrop", drop, 0);
      end
      if (k == 9) begin
        chk("drop.accept_done", busy, 0);
        chk("drop.accept_count", count, 8'h40);
      end
    end
    // reset while ext_sync_o is high
    tick();
    sync_offset = 8'd2;
    en_ext = 1'b1;
    clk_offset = 8'h50;
    sync_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      sync_req = 1'b0;
    end
    chk("rst.ext_before", ext, 1);
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    req_seq(2, 1'b1, 8'h55, 1'b0);
    // counter and phase wraps
    req_seq(0, 1'b0, 8'hF0, 1'b0);
    chk("wrap.count_start", count, 8'hF4);
    chk("wrap.phase_start", phase, 4);
    repeat (11) tick();
    chk("wrap.count_ff", count, 8'hFF);
    chk("wrap.phase_7", phase, 7);
    tick();
    chk("wrap.count_00", count, 8'h00);
    chk("wrap.phase_0", phase, 0);
    // maximum offset
    sync_offset = 8'd255;
    en_ext = 1'b0;
    clk_offset = 8'h77;
    sync_req = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      tick();
      sync_req = 1'b0;
      if (k == 255) begin
        chk("max.sync_early", sync, 0);
        chk("max.busy", busy, 1);
      end
      if (k == 256) chk("max.sync", sync, 1);
      if (k == 257) begin
        chk("max.busy_done", busy, 0);
        chk("max.count", count, 8'h77);
        chk("max.phase", phase, 0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
